ingreso_operando_param: RTL

Parametrised keypad digit-entry block for the calculator datapath. It is the successor of the fixed 4-digit, single-operand entry FSM.
- Builds an NDIG-digit BCD number from debounced keypad codes, with rising-edge detection of key strobes.
- Supports backspace, clear and overflow flagging.
- Commits up to NOPS operands, in order, to the ALU over a valid/ack handshake.

---
 rtl/ingreso_operando_param_if.sv | 30 +++
 rtl/ingreso_operando_param.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ingreso_operando_param_if.sv
// Operand handshake between the digit-entry block and the ALU.
// The master presents a committed operand and holds it until the slave acks.
interface ingreso_operando_param_if #(
  parameter int NDIG = 4,
  parameter int NOPS = 2
);
  localparam int IW = $clog2(NOPS);

  logic [4*NDIG-1:0] operando_dato;
  logic [IW-1:0]     operando_idx;
  logic              operando_valido;
  logic              operando_ultimo;
  logic              operando_ack;

  modport master (
    output operando_dato,
    output operando_idx,
    output operando_valido,
    output operando_ultimo,
    input  operando_ack
  );

  modport slave (
    input  operando_dato,
    input  operando_idx,
    input  operando_valido,
    input  operando_ultimo,
    output operando_ack
  );
endinterface

// File: rtl/ingreso_operando_param.sv
// Keypad digit entry: builds an NDIG-digit BCD number from key strobes and
// commits operands, in order, to the ALU over a valid/ack handshake.
//
// state   | meaning
// --------+------------------------------------------------------------
// ESPERAR | accepting key events (digits, backspace, clear, commit)
// VALIDO  | operand presented to the ALU; key events ignored and lost
module ingreso_operando_param #(
  parameter  int NDIG = 4,
  parameter  int NOPS = 2,
  localparam int CW   = $clog2(NDIG + 1),
  localparam int IW   = $clog2(NOPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ingreso_en,
  input  logic                 tecla_valida,
  input  logic [3:0]           tecla_codigo,
  output logic [4*NDIG-1:0]    numero,
  output logic [CW-1:0]        contador,
  output logic                 desborde,
  output logic                 actualizar,
  ingreso_operando_param_if.master alu
);

  typedef enum logic {ESPERAR, VALIDO} estado_t;

  estado_t           state_q, state_d;
  logic              tecla_prev;
  logic [4*NDIG-1:0] numero_q, numero_d;
  logic [CW-1:0]     contador_q, contador_d;
  logic              desborde_q, desborde_d;
  logic              actualizar_q, actualizar_d;
  logic [4*NDIG-1:0] dato_q, dato_d;
  logic [IW-1:0]     oidx_q, oidx_d;
  logic              valido_q, valido_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              evento;
  logic [4*NDIG-1:0] numero_desp;

  // Rising edge of the key strobe, only while entry is enabled and idle.
  assign evento = tecla_valida && !tecla_prev && ingreso_en && (state_q == ESPERAR);

  // Entry shifted one digit up with the new key code in the low nibble.
  always_comb begin
    numero_desp      = numero_q << 4;
    numero_desp[3:0] = tecla_codigo;
  end

  // Next-state and datapath update for key events and the ALU handshake.
  always_comb begin
    state_d      = state_q;
    numero_d     = numero_q;
    contador_d   = contador_q;
    desborde_d   = desborde_q;
    actualizar_d = 1'b0;
    dato_d       = dato_q;
    oidx_d       = oidx_q;
    valido_d     = valido_q;
    idx_d        = idx_q;
    case (state_q)
      ESPERAR: begin
        if (evento) begin
          if (tecla_codigo <= 4'd9) begin
            if (contador_q == CW'(NDIG)) begin
              desborde_d = 1'b1;
            end else begin
              actualizar_d = 1'b1;
              // A leading zero is acknowledged but does not occupy a digit.
              if ((contador_q != '0) || (tecla_codigo != 4'd0)) begin
                numero_d   = numero_desp;
                contador_d = contador_q + 1'b1;
              end
            end
          end else begin
            case (tecla_codigo)
              4'hA: begin
                numero_d     = numero_q >> 4;
                if (contador_q != '0) contador_d = contador_q - 1'b1;
                desborde_d   = 1'b0;
                actualizar_d = 1'b1;
              end
              4'hB: begin
                numero_d     = '0;
                contador_d   = '0;
                desborde_d   = 1'b0;
                actualizar_d = 1'b1;
              end
              4'hE: begin
                dato_d       = numero_q;
                oidx_d       = idx_q;
                valido_d     = 1'b1;
                numero_d     = '0;
                contador_d   = '0;
                desborde_d   = 1'b0;
                actualizar_d = 1'b1;
                state_d      = VALIDO;
              end
              default: ;
            endcase
          end
        end
      end
      VALIDO: begin
        if (alu.operando_ack) begin
          valido_d = 1'b0;
          state_d  = ESPERAR;
          idx_d    = (idx_q == IW'(NOPS - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = ESPERAR;
    endcase
  end

  // State and datapath registers; reset drops any pending operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ESPERAR;
      tecla_prev   <= 1'b0;
      numero_q     <= '0;
      contador_q   <= '0;
      desborde_q   <= 1'b0;
      actualizar_q <= 1'b0;
      dato_q       <= '0;
      oidx_q       <= '0;
      valido_q     <= 1'b0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      tecla_prev   <= tecla_valida;
      numero_q     <= numero_d;
      contador_q   <= contador_d;
      desborde_q   <= desborde_d;
      actualizar_q <= actualizar_d;
      dato_q       <= dato_d;
      oidx_q       <= oidx_d;
      valido_q     <= valido_d;
      idx_q        <= idx_d;
    end
  end

  assign numero              = numero_q;
  assign contador            = contador_q;
  assign desborde            = desborde_q;
  assign actualizar          = actualizar_q;
  assign alu.operando_dato   = dato_q;
  assign alu.operando_idx    = oidx_q;
  assign alu.operando_valido = valido_q;
  assign alu.operando_ultimo = valido_q && (oidx_q == IW'(NOPS - 1));

endmodule
